baud_rate_gen: RTL and testbench

- Runtime-programmable UART baud/oversample tick generator with a fractional divider.
- Sits between the system clock and the UART TX/RX engines and replaces the fixed-divisor tick generator.
- Produces an oversample tick (SampleTick), a bit-rate tick (BaudTick) and a mid-bit strobe (MidBit) for RX centre sampling.

---
 rtl/baud_rate_gen.sv | 84 ++++++++
 tb/tb_baud_rate_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_rate_gen.sv
// UART tick generator: fractional clock divider producing oversample, bit-rate
// and mid-bit strobes. All outputs are registered single-cycle pulses.
module baud_rate_gen #(
  parameter int DIV_WIDTH   = 16,
  parameter int FRAC_BITS   = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 326
) (
  input  logic                 CLK,
  input  logic                 Reset_n,
  input  logic                 Enable,
  input  logic                 Load,
  input  logic [DIV_WIDTH-1:0] Divisor,
  input  logic [FRAC_BITS-1:0] DivFrac,
  output logic                 SampleTick,
  output logic                 BaudTick,
  output logic                 MidBit
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]      OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_WIDTH:0]   P_ONE   = (DIV_WIDTH+1)'(1);

  logic [DIV_WIDTH-1:0] div_reg;
  logic [FRAC_BITS-1:0] frac_reg;
  logic [DIV_WIDTH-1:0] cnt;
  logic [FRAC_BITS-1:0] acc;
  logic                 carry;
  logic [OS_W-1:0]      os;

  logic [DIV_WIDTH:0]   period;
  logic [FRAC_BITS:0]   acc_sum;
  logic                 wrap;

  function automatic logic [OS_W-1:0] next_os(input logic [OS_W-1:0] cur);
    return (cur == OS_LAST) ? '0 : cur + OS_W'(1);
  endfunction

  // Period is one bit wider than the divisor so DivReg = max with a carry cannot overflow
  assign period  = {1'b0, div_reg} + {{DIV_WIDTH{1'b0}}, carry};
  assign acc_sum = {1'b0, acc} + {1'b0, frac_reg};
  assign wrap    = (div_reg != '0) && ({1'b0, cnt} == period - P_ONE);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      div_reg    <= DIV_WIDTH'(DEFAULT_DIV);
      frac_reg   <= '0;
      cnt        <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      os         <= '0;
      SampleTick <= 1'b0;
      BaudTick   <= 1'b0;
      MidBit     <= 1'b0;
    end else if (Load || !Enable || (div_reg == '0)) begin
      if (Load) begin
        div_reg  <= Divisor;
        frac_reg <= DivFrac;
      end
      cnt        <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      os         <= '0;
      SampleTick <= 1'b0;
      BaudTick   <= 1'b0;
      MidBit     <= 1'b0;
    end else if (wrap) begin
      // The carry out of the phase accumulator stretches the next period by one clock
      cnt          <= '0;
      {carry, acc} <= acc_sum;
      os           <= next_os(os);
      SampleTick   <= 1'b1;
      BaudTick     <= (os == OS_LAST);
      MidBit       <= (os == OS_MID);
    end else begin
      cnt        <= cnt + DIV_WIDTH'(1);
      SampleTick <= 1'b0;
      BaudTick   <= 1'b0;
      MidBit     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_rate_gen.sv
// Scoreboard bench for baud_rate_gen: expected tick events are queued from the
// divisor arithmetic and compared against events observed on the outputs.
module tb_baud_rate_gen;

  localparam int DIV_WIDTH = 16;
  localparam int FRAC_BITS = 4;
  localparam int OVS       = 16;
  localparam int FRAC_ONE  = 1 << FRAC_BITS;

  typedef struct {
    int         cyc;
    logic [2:0] m;   // {MidBit, BaudTick, SampleTick}
  } ev_t;

  logic                 clk;
  logic                 Reset_n;
  logic                 Enable;
  logic                 Load;
  logic [DIV_WIDTH-1:0] Divisor;
  logic [FRAC_BITS-1:0] DivFrac;
  logic                 SampleTick;
  logic                 BaudTick;
  logic                 MidBit;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  baud_rate_gen #(
    .DIV_WIDTH  (DIV_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .OVERSAMPLE (OVS),
    .DEFAULT_DIV(326)
  ) dut (
    .CLK       (clk),
    .Reset_n   (Reset_n),
    .Enable    (Enable),
    .Load      (Load),
    .Divisor   (Divisor),
    .DivFrac   (DivFrac),
    .SampleTick(SampleTick),
    .BaudTick  (BaudTick),
    .MidBit    (MidBit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick k lands k*D + floor((k-1)*F/2^FRAC_BITS) clocks after base.
  function automatic void add_ticks(input int base, input int d, input int f, input int ncyc);
    int t;
    logic [2:0] m;
    if (d == 0) return;
    for (int k = 1; k * d <= ncyc; k++) begin
      t = k * d + ((k - 1) * f) / FRAC_ONE;
      if (t > ncyc) break;
      m = 3'b001;
      if (k % OVS == 0) m = m | 3'b010;
      if (k % OVS == OVS / 2) m = m | 3'b100;
      exp_q.push_back('{base + t, m});
    end
  endfunction

  task automatic collect(input int n);
    repeat (n) begin
      @(negedge clk);
      if (SampleTick || BaudTick || MidBit)
        obs_q.push_back('{cyc, {MidBit, BaudTick, SampleTick}});
    end
  endtask

  task automatic do_load(input int d, input int f, output int base);
    @(negedge clk);
    Divisor = DIV_WIDTH'(d);
    DivFrac = FRAC_BITS'(f);
    Load    = 1'b1;
    @(negedge clk);
    Load = 1'b0;
    base = cyc;
  endtask

  task automatic test_reset;
    int  base;
    ev_t e, o;
    Reset_n = 1'b0; Enable = 1'b1; Load = 1'b0; Divisor = '0; DivFrac = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({MidBit, BaudTick, SampleTick} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 000", {MidBit, BaudTick, SampleTick});
    end
    Reset_n = 1'b1;
    base = cyc;
    add_ticks(base, 326, 0, 5216 + 5);
    collect(5216 + 5);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.m !== e.m) begin
        errors++;
        $display("FAIL reset_event: got cycle %0d mask %b, expected cycle %0d mask %b", o.cyc, o.m, e.cyc, e.m);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_int_div;
    int  base;
    ev_t e, o;
    do_load(4, 0, base);
    checks++;
    if ({MidBit, BaudTick, SampleTick} !== 3'b000) begin
      errors++;
      $display("FAIL int_load_clear: got %b, expected 000", {MidBit, BaudTick, SampleTick});
    end
    add_ticks(base, 4, 0, 70);
    collect(70);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL int_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.m !== e.m) begin
        errors++;
        $display("FAIL int_event: got cycle %0d mask %b, expected cycle %0d mask %b", o.cyc, o.m, e.cyc, e.m);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_frac_div;
    int  base;
    int  n;
    ev_t e, o;
    do_load(4, 8, base);
    add_ticks(base, 4, 8, 1600);
    collect(1600);
    n = 0;
    foreach (obs_q[i]) if (obs_q[i].m[0]) n++;
    checks++;
    if (n < 355 || n > 356) begin
      errors++;
      $display("FAIL frac_rate: got %0d SampleTicks in 1600 clocks, expected 355 or 356", n);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL frac_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.m !== e.m) begin
        errors++;
        $display("FAIL frac_event: got cycle %0d mask %b, expected cycle %0d mask %b", o.cyc, o.m, e.cyc, e.m);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_div_bounds;
    int  base;
    ev_t e, o;
    do_load(1, 0, base);
    add_ticks(base, 1, 0, 48);
    collect(48);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL div1_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.m !== e.m) begin
        errors++;
        $display("FAIL div1_event: got cycle %0d mask %b, expected cycle %0d mask %b", o.cyc, o.m, e.cyc, e.m);
      end
    end
    exp_q.delete(); obs_q.delete();
    do_load(0, 5, base);
    checks++;
    if ({MidBit, BaudTick, SampleTick} !== 3'b000) begin
      errors++;
      $display("FAIL div0_load_clear: got %b, expected 000", {MidBit, BaudTick, SampleTick});
    end
    collect(1000);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL div0_halt: got %0d events (first at cycle %0d), expected 0", obs_q.size(), obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  task automatic test_enable;
    int  base;
    ev_t e, o;
    do_load(10, 0, base);
    add_ticks(base, 10, 0, 25);
    collect(25);
    @(negedge clk);
    Enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({MidBit, BaudTick, SampleTick} !== 3'b000) begin
        errors++;
        $display("FAIL enable_low: got %b in disabled cycle %0d, expected 000", {MidBit, BaudTick, SampleTick}, i);
      end
    end
    Enable = 1'b1;
    base = cyc;
    add_ticks(base, 10, 0, 170);
    collect(170);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL enable_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.m !== e.m) begin
        errors++;
        $display("FAIL enable_event: got cycle %0d mask %b, expected cycle %0d mask %b", o.cyc, o.m, e.cyc, e.m);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset;
    int  base;
    bit  found;
    ev_t e, o;
    do_load(4, 0, base);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (BaudTick === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL areset_wait: BaudTick not seen within 100 clocks, expected one by 64");
    end
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if ({MidBit, BaudTick, SampleTick} !== 3'b000) begin
      errors++;
      $display("FAIL areset_async: got %b before next edge, expected 000", {MidBit, BaudTick, SampleTick});
    end
    @(negedge clk);
    Reset_n = 1'b1;
    base = cyc;
    add_ticks(base, 326, 0, 700);
    collect(700);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL areset_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.m !== e.m) begin
        errors++;
        $display("FAIL areset_event: got cycle %0d mask %b, expected cycle %0d mask %b", o.cyc, o.m, e.cyc, e.m);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_int_div();
    test_frac_div();
    test_div_bounds();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
